// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and program loader:
// the NOP fill value, the loader FSM state encoding and the byte-lane index type.
package imem_pkg;

    // addi x0,x0,0 -- fed to the core whenever no valid instruction is available
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Index of the byte lane inside a 32-bit word (little-endian order)
    typedef logic [1:0] lane_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: IMEM_DEPTH x 32 words, one synchronous write port
// and one asynchronous read port so the core can fetch in a single cycle.
// Contents are deliberately not reset.
module imem_array
    import imem_pkg::*;
#(
    parameter int IMEM_DEPTH  = 256,
    parameter int IMEM_ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [IMEM_ADDR_W-1:0] waddr,
    input  logic [31:0]            wdata,
    input  logic [IMEM_ADDR_W-1:0] raddr,
    output logic [31:0]            rdata
);

    logic [31:0] mem [IMEM_DEPTH];

    // Write port: one word per clock when the loader completes a word
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is combinational to match the processor's single-cycle fetch
    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a byte-stream program loader in front of it.
// Bytes arrive little-endian over a valid/ready port, are packed into words,
// and the core is held in reset until a load finishes without overflow.
// Optional feature: define IMEM_CHECKSUM_EN to add a 32-bit running sum
// of all words written by the current load on port checksum.
module imem_loader
    import imem_pkg::*;
#(
    parameter int IMEM_DEPTH  = 256,
    parameter int IMEM_ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [7:0]             ld_byte,
    input  logic                   ld_last,
    input  logic [31:0]            pc,
    output logic [31:0]            inst,
    output logic                   core_nrst,
    output logic                   ld_done,
    output logic                   ld_err,
    output logic                   pc_fault,
    output logic [IMEM_ADDR_W:0]   word_cnt
`ifdef IMEM_CHECKSUM_EN
    ,
    output logic [31:0]            checksum
`endif
);

    localparam logic [IMEM_ADDR_W:0] WORDS_FULL = (IMEM_ADDR_W+1)'(IMEM_DEPTH);
    localparam logic [IMEM_ADDR_W:0] WORD_ONE   = (IMEM_ADDR_W+1)'(1);

    state_t                 state_q, state_d;
    lane_t                  byte_cnt_q, byte_cnt_d;
    logic [31:0]            asm_q, asm_d;
    logic [IMEM_ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic                   core_nrst_q, core_nrst_d;
    logic                   ld_done_q, ld_done_d;
    logic                   ld_err_q, ld_err_d;
`ifdef IMEM_CHECKSUM_EN
    logic [31:0]            checksum_q, checksum_d;
`endif

    logic                   accept;
    logic                   full;
    logic                   mem_we;
    logic [31:0]            merged;
    logic [31:0]            rdata;
    logic [IMEM_ADDR_W-1:0] ridx;
    logic                   pc_upper;
    logic                   idx_oob;

    // A restart pulse has priority over a byte offered in the same cycle
    assign ld_ready = (state_q == LOAD) && !ld_start;
    assign accept   = ld_valid && ld_ready;
    assign full     = (word_cnt_q == WORDS_FULL);

    // Drop the incoming byte into its lane; upper lanes stay zero because the
    // assembly register is cleared after every word is written
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign merged[8*gi +: 8] = (byte_cnt_q == lane_t'(gi)) ? ld_byte : asm_q[8*gi +: 8];
    end

    // A word is committed on its 4th byte, or early when the last byte arrives
    assign mem_we = accept && !full && (ld_last || (byte_cnt_q == 2'd3));

    // Next-state logic for the loader FSM, counters and registered outputs
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        word_cnt_d  = word_cnt_q;
        core_nrst_d = core_nrst_q;
        ld_done_d   = ld_done_q;
        ld_err_d    = ld_err_q;
`ifdef IMEM_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        if (ld_start) begin
            state_d     = LOAD;
            byte_cnt_d  = '0;
            asm_d       = '0;
            word_cnt_d  = '0;
            core_nrst_d = 1'b0;
            ld_done_d   = 1'b0;
            ld_err_d    = 1'b0;
`ifdef IMEM_CHECKSUM_EN
            checksum_d  = '0;
`endif
        end else if (accept) begin
            if (full) begin
                // No room left: drop the byte and park in ERR
                state_d  = ERR;
                ld_err_d = 1'b1;
            end else if (mem_we) begin
                word_cnt_d = word_cnt_q + WORD_ONE;
                asm_d      = '0;
                byte_cnt_d = '0;
`ifdef IMEM_CHECKSUM_EN
                checksum_d = checksum_q + merged;
`endif
                if (ld_last) begin
                    state_d     = RUN;
                    core_nrst_d = 1'b1;
                    ld_done_d   = 1'b1;
                end
            end else begin
                asm_d      = merged;
                byte_cnt_d = lane_t'(byte_cnt_q + 2'd1);
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            word_cnt_q  <= '0;
            core_nrst_q <= 1'b0;
            ld_done_q   <= 1'b0;
            ld_err_q    <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            word_cnt_q  <= word_cnt_d;
            core_nrst_q <= core_nrst_d;
            ld_done_q   <= ld_done_d;
            ld_err_q    <= ld_err_d;
`ifdef IMEM_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    imem_array #(
        .IMEM_DEPTH  (IMEM_DEPTH),
        .IMEM_ADDR_W (IMEM_ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (word_cnt_q[IMEM_ADDR_W-1:0]),
        .wdata (merged),
        .raddr (ridx),
        .rdata (rdata)
    );

    // Fetch path: only aligned, in-range, loaded words reach the core in RUN
    assign ridx     = pc[IMEM_ADDR_W+1:2];
    assign pc_upper = |pc[31:IMEM_ADDR_W+2];
    assign idx_oob  = ({1'b0, ridx} >= word_cnt_q);
    assign pc_fault = (state_q == RUN) && ((pc[1:0] != 2'b00) || pc_upper || idx_oob);
    assign inst     = ((state_q == RUN) && !pc_fault) ? rdata : NOP_INST;

    assign core_nrst = core_nrst_q;
    assign ld_done   = ld_done_q;
    assign ld_err    = ld_err_q;
    assign word_cnt  = word_cnt_q;
`ifdef IMEM_CHECKSUM_EN
    assign checksum  = checksum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed load sequences push expected
// observations into a scoreboard queue; a monitor on the falling edge pops
// and compares them against the live DUT outputs.
module tb_imem_loader;
    import imem_pkg::*;

    localparam int F_INST  = 0;
    localparam int F_FAULT = 1;
    localparam int F_WCNT  = 2;
    localparam int F_CNRST = 3;
    localparam int F_DONE  = 4;
    localparam int F_ERR   = 5;
    localparam int F_READY = 6;
    localparam int F_CSUM  = 7;
    localparam int F_MEM   = 8;

    typedef struct {
        string       name;
        int          field;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [7:0]  ld_byte = 8'h00;
    logic        ld_last = 1'b0;
    logic [31:0] pc = 32'h0;
    logic [31:0] inst;
    logic        core_nrst;
    logic        ld_done;
    logic        ld_err;
    logic        pc_fault;
    logic [8:0]  word_cnt;
`ifdef IMEM_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          checks = 0;
    int          failures = 0;

    imem_loader #(
        .IMEM_DEPTH  (256),
        .IMEM_ADDR_W (8)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_byte   (ld_byte),
        .ld_last   (ld_last),
        .pc        (pc),
        .inst      (inst),
        .core_nrst (core_nrst),
        .ld_done   (ld_done),
        .ld_err    (ld_err),
        .pc_fault  (pc_fault),
        .word_cnt  (word_cnt)
`ifdef IMEM_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sample(input int field, input int idx);
        logic [31:0] v;
        v = 32'h0;
        case (field)
            F_INST:  v = inst;
            F_FAULT: v = {31'b0, pc_fault};
            F_WCNT:  v = {23'b0, word_cnt};
            F_CNRST: v = {31'b0, core_nrst};
            F_DONE:  v = {31'b0, ld_done};
            F_ERR:   v = {31'b0, ld_err};
            F_READY: v = {31'b0, ld_ready};
`ifdef IMEM_CHECKSUM_EN
            F_CSUM:  v = checksum;
`endif
            F_MEM:   v = dut.u_array.mem[idx];
            default: v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    // Monitor: compare every pending expectation against the DUT mid-cycle
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_act = sample(mon_e.field, mon_e.idx);
            checks++;
            if (mon_act !== mon_e.exp) begin
                failures++;
                $display("FAIL %s actual=%08h required=%08h", mon_e.name, mon_act, mon_e.exp);
            end else begin
                $display("ok   %s value=%08h", mon_e.name, mon_act);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input string name, input int field, input int idx, input logic [31:0] exp);
        exp_t e;
        e.name  = name;
        e.field = field;
        e.idx   = idx;
        e.exp   = exp;
        sb_q.push_back(e);
        for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s monitor_timeout actual=pending required=consumed", name);
            sb_q.delete();
        end
    endtask

    task automatic expect_val(input string name, input int field, input logic [31:0] exp);
        expect_at(name, field, 0, exp);
    endtask

    task automatic fetch(input string name, input logic [31:0] addr,
                         input logic [31:0] exp_inst, input logic exp_fault);
        pc = addr;
        expect_val({name, "_inst"}, F_INST, exp_inst);
        expect_val({name, "_fault"}, F_FAULT, {31'b0, exp_fault});
    endtask

    task automatic start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        nrst = 1'b0;
        #12;
        expect_val("rst_core_nrst", F_CNRST, 32'd0);
        expect_val("rst_ready", F_READY, 32'd0);
        expect_val("rst_done", F_DONE, 32'd0);
        expect_val("rst_err", F_ERR, 32'd0);
        expect_val("rst_wcnt", F_WCNT, 32'd0);
        fetch("rst_pc0", 32'h0, NOP_INST, 1'b0);
        tick();
        nrst = 1'b1;
        tick();

        // Single word load
        start();
        expect_val("t1_ready", F_READY, 32'd1);
        send(8'h13, 1'b0);
        send(8'h00, 1'b0);
        send(8'h30, 1'b0);
        expect_val("t1_core_nrst_before", F_CNRST, 32'd0);
        send(8'h00, 1'b1);
        expect_val("t1_core_nrst_after", F_CNRST, 32'd1);
        expect_val("t1_wcnt", F_WCNT, 32'd1);
        expect_val("t1_done", F_DONE, 32'd1);
        expect_val("t1_ready_run", F_READY, 32'd0);
        fetch("t1_pc0", 32'h0, 32'h0030_0013, 1'b0);
        fetch("t1_pc4", 32'h4, NOP_INST, 1'b1);

        // Six bytes: one full and one partial word
        start();
        expect_val("t2_core_nrst_restart", F_CNRST, 32'd0);
        expect_val("t2_wcnt_cleared", F_WCNT, 32'd0);
        for (int i = 1; i <= 6; i++) send(8'(i), (i == 6));
        expect_val("t2_wcnt", F_WCNT, 32'd2);
        fetch("t2_pc0", 32'h0, 32'h0403_0201, 1'b0);
        fetch("t2_pc4", 32'h4, 32'h0000_0605, 1'b0);
        fetch("t2_pc8", 32'h8, NOP_INST, 1'b1);
        fetch("t2_pc2", 32'h2, NOP_INST, 1'b1);
        fetch("t2_pc1000", 32'h1000, NOP_INST, 1'b1);
`ifdef IMEM_CHECKSUM_EN
        expect_val("t2_csum", F_CSUM, 32'h0403_0806);
`endif

        // Exactly full memory ending with ld_last is legal
        start();
        for (int i = 0; i < 1024; i++) send(8'(i) ^ 8'h5A, (i == 1023));
        expect_val("t3_err", F_ERR, 32'd0);
        expect_val("t3_done", F_DONE, 32'd1);
        expect_val("t3_wcnt", F_WCNT, 32'd256);
        fetch("t3_pc3fc", 32'h3FC, 32'hA5A4_A7A6, 1'b0);
        fetch("t3_pc0", 32'h0, 32'h5958_5B5A, 1'b0);
        fetch("t3_pc400", 32'h400, NOP_INST, 1'b1);

        // One byte beyond capacity overflows into ERR
        start();
        for (int i = 0; i < 1024; i++) send(8'(i), 1'b0);
        send(8'h77, 1'b1);
        expect_val("t4_err", F_ERR, 32'd1);
        expect_val("t4_core_nrst", F_CNRST, 32'd0);
        expect_val("t4_ready", F_READY, 32'd0);
        expect_val("t4_done", F_DONE, 32'd0);
        expect_val("t4_wcnt", F_WCNT, 32'd256);
        fetch("t4_pc0", 32'h0, NOP_INST, 1'b0);
        expect_at("t4_mem255", F_MEM, 255, 32'hFFFE_FDFC);
        expect_at("t4_mem0", F_MEM, 0, 32'h0302_0100);

        // Restart from ERR, then restart again mid-load with a byte offered
        start();
        expect_val("t5_err_cleared", F_ERR, 32'd0);
        for (int i = 0; i < 8; i++) send(8'h11 + 8'(i), 1'b0);
        expect_val("t5_wcnt_mid", F_WCNT, 32'd2);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_byte  = 8'h99;
        expect_val("t5_ready_on_start", F_READY, 32'd0);
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b1);
        expect_val("t5_wcnt", F_WCNT, 32'd1);
        fetch("t5_pc0", 32'h0, 32'hDDCC_BBAA, 1'b0);
        fetch("t5_pc4", 32'h4, NOP_INST, 1'b1);

        // ld_last on the very first byte writes one zero-padded word
        start();
        send(8'h7F, 1'b1);
        expect_val("t6_wcnt", F_WCNT, 32'd1);
        fetch("t6_pc0", 32'h0, 32'h0000_007F, 1'b0);

        // Asynchronous reset in the middle of a load
        start();
        for (int i = 0; i < 5; i++) send(8'hE0 + 8'(i), 1'b0);
        #2;
        nrst = 1'b0;
        #1;
        pc = 32'h0;
        expect_val("t7_ready", F_READY, 32'd0);
        expect_val("t7_wcnt", F_WCNT, 32'd0);
        expect_val("t7_core_nrst", F_CNRST, 32'd0);
        fetch("t7_pc0", 32'h0, NOP_INST, 1'b0);
        tick();
        nrst = 1'b1;
        tick();

`ifdef IMEM_CHECKSUM_EN
        // Checksum wraps modulo 2^32 and clears on restart
        start();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b1);
        expect_val("t8_done", F_DONE, 32'd1);
        expect_val("t8_csum", F_CSUM, 32'h0000_0000);
        start();
        send(8'h05, 1'b0);
        expect_val("t8_csum_pending", F_CSUM, 32'h0000_0000);
        send(8'h00, 1'b1);
        expect_val("t8_csum_small", F_CSUM, 32'h0000_0005);
        start();
        expect_val("t8_csum_cleared", F_CSUM, 32'h0000_0000);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction memory plus program-load front end.
- Sits directly upstream of `processor`: it drives `inst` combinationally from the processor's `pc`.
- Accepts a little-endian byte stream over a valid/ready port and assembles it into 32-bit words in a word-addressed array.
- Holds the core in reset through `core_nrst` until a load completes cleanly.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit instruction words.
- IMEM_ADDR_W, 8, word-address width; must satisfy 2**IMEM_ADDR_W == IMEM_DEPTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- nrst  in  1  asynchronous, active-low reset.
- ld_start  in  1  single-cycle pulse; begins a new program load.
- ld_valid  in  1  load byte valid.
- ld_ready  out  1  load byte accepted this cycle when high together with ld_valid.
- ld_byte  in  8  load data byte; first byte is instruction bits [7:0].
- ld_last  in  1  marks the final byte of the program; qualified by ld_valid & ld_ready.
- pc  in  32  byte address from the processor.
- inst  out  32  instruction for the processor.
- core_nrst  out  1  registered reset to the processor, active-low.
- ld_done  out  1  high in RUN.
- ld_err  out  1  high in ERR (program overflow).
- pc_fault  out  1  combinational; high when pc is misaligned or out of range while in RUN.
- word_cnt  out  IMEM_ADDR_W+1  number of words written by the current or last load.

Behaviour:
- Reset values: state=IDLE, core_nrst=0, ld_ready=0, ld_done=0, ld_err=0, word_cnt=0, byte_cnt=0, word assembly register=0. Memory contents are not reset.
- FSM states: IDLE, LOAD, RUN, ERR.
- IDLE:
  - ld_ready=0; inst=NOP_INST.
  - ld_start -> LOAD, clearing word_cnt and byte_cnt.
- LOAD:
  - ld_ready=1; core_nrst=0.
  - Each accepted byte is stored into lane byte_cnt of the assembly register, then byte_cnt increments modulo 4.
  - On the 4th byte (byte_cnt==3), the completed word is written to mem[word_cnt] in the same edge; word_cnt increments and the assembly register clears.
- Load termination (ld_last accepted):
  - The current word is written even if partial; unfilled upper bytes are zero.
  - word_cnt increments; next state is RUN.
  - ld_last on the very first byte writes one word.
- Overflow:
  - A byte accepted while word_cnt==IMEM_DEPTH goes to ERR.
  - The byte is dropped, memory is untouched, and ld_err is set the next cycle.
  - Exactly IMEM_DEPTH full words ending with ld_last is legal: the RUN path wins.
- RUN:
  - core_nrst=1, registered and asserted on the edge entering RUN, so the processor sees reset released one cycle after the last byte's edge.
  - ld_ready=0 and ld_done=1.
- Instruction read:
  - inst = mem[pc[IMEM_ADDR_W+1:2]] with no latency (asynchronous read), matching the processor's single-cycle fetch.
- Fault cases in RUN:
  - If pc[1:0]!=0, or pc[31:IMEM_ADDR_W+2]!=0, or the word index >= word_cnt, then inst=NOP_INST and pc_fault=1.
- Outside RUN: inst=NOP_INST and pc_fault=0.
- ERR:
  - core_nrst=0, ld_err=1, ld_ready=0.
  - Left only via ld_start (-> LOAD, clears ld_err) or nrst.
- ld_start in LOAD, RUN or ERR:
  - Restarts the load: goes to LOAD, clears the counters, and drops core_nrst on the same edge.
  - A byte presented in the same cycle as ld_start is not accepted (ld_ready=0 that cycle by priority).
- nrst assertion mid-load: state returns to IDLE immediately; partially written memory remains but is unreachable because word_cnt=0.

Optional Feature:
- Macro IMEM_CHECKSUM_EN.
- When defined:
  - Adds output port checksum (32 bits), the modulo-2^32 sum of all words written by the current load, zero-padded partial word included.
  - checksum is cleared on ld_start and reset, and is valid in RUN.
- When undefined: the port and adder are absent; all other behaviour is identical.

Decomposition:
- Package imem_pkg:
  - NOP_INST = 32'h0000_0013 (addi x0,x0,0).
  - State enum {IDLE, LOAD, RUN, ERR}.
  - Byte-lane index type (2 bits).
- Sub-module imem_array:
  - IMEM_DEPTH x 32 storage.
  - One synchronous write port (we, waddr, wdata) and one asynchronous read port.
  - Keeps storage separate from the loader FSM.

Test Plan:
- Reset, then ld_start, then bytes 13,00,30,00 with ld_last on the last -> word 0 = 0x00300013, word_cnt=1, core_nrst rises one cycle after the last byte, and pc=0 gives inst=0x00300013.
- Load 6 bytes 01..06 with ld_last on the 6th -> word 0 = 0x04030201, word 1 = 0x00000605, word_cnt=2, and pc=8 gives NOP_INST with pc_fault=1.
- In RUN, pc=2 -> inst=0x00000013 and pc_fault=1; pc=0x1000 with depth 256 -> pc_fault=1.
- Load exactly 1024 bytes with ld_last on the last -> RUN and ld_err=0; repeat with 1025 bytes and ld_last on the last -> ERR, ld_err=1, core_nrst=0, word 255 unchanged.
- Mid-load (2 words written) pulse ld_start, then load 4 bytes AA,BB,CC,DD with ld_last -> word_cnt=1, word 0 = 0xDDCCBBAA; separately, assert nrst mid-load -> IDLE and inst=NOP_INST.
- With IMEM_CHECKSUM_EN defined, load words 0x00000001 and 0xFFFFFFFF -> checksum=0x00000000 in RUN; then ld_start clears checksum to 0.
